// File: rtl/fetch_controller_if.sv
// -----------------------------------------------------------------------------
// fetch_controller_if
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and the instruction memory port (slave).
//   req    master->slave  fetch request, held until ack
//   addr   master->slave  fetch address, stable while req=1
//   ack    slave->master  request accepted, rdata valid in the same cycle
//   rdata  slave->master  fetched instruction word
// -----------------------------------------------------------------------------
interface fetch_controller_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              req;
  logic [DATA_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface : fetch_controller_if

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Instruction-fetch sequencer. Owns the fetch PC, issues one instruction-memory
// request at a time, and hands fetched words to decode through a primary entry
// backed by a one-deep skid entry. Applies X/M redirects (M wins), including
// redirects that land while a request is outstanding, drives pipeline flushes,
// and parks the front end on halt until reset.
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   imem          instruction-memory bus (master side)
//   hlt_i         halt request (level)
//   stall_i       decode not accepting the primary entry
//   ct_taken_x_i  execute-stage redirect,  ct_pc_x_i its target
//   ct_taken_m_i  memory-stage redirect,   ct_pc_m_i its target (overrides X)
//   if_valid_o    primary entry valid
//   if_ir_o       primary instruction word
//   if_pc_o       primary instruction address
//   flush_d_o     kill decode-stage instruction
//   flush_x_o     kill execute-stage instruction
//   halted_o      front end parked
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.master imem,
  input  logic               hlt_i,
  input  logic               stall_i,
  input  logic               ct_taken_x_i,
  input  logic [DATA_W-1:0]  ct_pc_x_i,
  input  logic               ct_taken_m_i,
  input  logic [DATA_W-1:0]  ct_pc_m_i,
  output logic               if_valid_o,
  output logic [DATA_W-1:0]  if_ir_o,
  output logic [DATA_W-1:0]  if_pc_o,
  output logic               flush_d_o,
  output logic               flush_x_o,
  output logic               halted_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] pend_pc_q, pend_pc_d;
  logic              discard_q, discard_d;
  logic              prim_v_q, prim_v_d;
  logic [DATA_W-1:0] prim_ir_q, prim_ir_d;
  logic [DATA_W-1:0] prim_pc_q, prim_pc_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_ir_q, skid_ir_d;
  logic [DATA_W-1:0] skid_pc_q, skid_pc_d;

  logic              redirect;
  logic [DATA_W-1:0] target;
  logic              consume;
  logic              halt_go;

  // Sequential fetch address; wraps naturally at 2^DATA_W.
  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] a);
    return a + DATA_W'(4);
  endfunction

  assign redirect = ct_taken_m_i | ct_taken_x_i;
  assign target   = ct_taken_m_i ? ct_pc_m_i : ct_pc_x_i;
  assign consume  = prim_v_q & ~stall_i;
  // An outstanding request is never abandoned: halt waits for its ack.
  assign halt_go  = hlt_i & ((state_q != FETCH) | imem.ack);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    discard_d = discard_q;
    prim_v_d  = prim_v_q;
    prim_ir_d = prim_ir_q;
    prim_pc_d = prim_pc_q;
    skid_v_d  = skid_v_q;
    skid_ir_d = skid_ir_q;
    skid_pc_d = skid_pc_q;

    // Decode takes the primary entry; the skid entry (if any) moves up.
    if (consume) begin
      prim_v_d = skid_v_q;
      skid_v_d = 1'b0;
      if (skid_v_q) begin
        prim_ir_d = skid_ir_q;
        prim_pc_d = skid_pc_q;
      end
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end
      FETCH: begin
        if (imem.ack) begin
          if (redirect) begin
            pc_d      = target;
            discard_d = 1'b0;
          end else if (discard_q) begin
            // Word belongs to the path abandoned by an earlier redirect.
            pc_d      = pend_pc_q;
            discard_d = 1'b0;
          end else begin
            pc_d = pc_inc(pc_q);
            if (!prim_v_d) begin
              prim_v_d  = 1'b1;
              prim_ir_d = imem.rdata;
              prim_pc_d = pc_q;
            end else begin
              skid_v_d  = 1'b1;
              skid_ir_d = imem.rdata;
              skid_pc_d = pc_q;
              state_d   = FULL;
            end
          end
        end else if (redirect) begin
          // Latest redirect wins; target applied once the pending ack arrives.
          discard_d = 1'b1;
          pend_pc_d = target;
        end
      end
      FULL: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (consume) begin
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != HALT) && redirect) begin
      prim_v_d = 1'b0;
      skid_v_d = 1'b0;
    end

    // Halt overrides any redirect at the same edge and drops acked data.
    if ((state_q == HALT) || halt_go) begin
      state_d   = HALT;
      pc_d      = RESET_PC;
      discard_d = 1'b0;
      prim_v_d  = 1'b0;
      skid_v_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      discard_q <= 1'b0;
      prim_v_q  <= 1'b0;
      prim_ir_q <= '0;
      prim_pc_q <= '0;
      skid_v_q  <= 1'b0;
      skid_ir_q <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      discard_q <= discard_d;
      prim_v_q  <= prim_v_d;
      prim_ir_q <= prim_ir_d;
      prim_pc_q <= prim_pc_d;
      skid_v_q  <= skid_v_d;
      skid_ir_q <= skid_ir_d;
      skid_pc_q <= skid_pc_d;
    end
  end

  assign imem.req   = (state_q == FETCH);
  assign imem.addr  = pc_q;
  assign if_valid_o = prim_v_q;
  assign if_ir_o    = prim_ir_q;
  assign if_pc_o    = prim_pc_q;
  assign flush_d_o  = redirect;
  assign flush_x_o  = ct_taken_m_i;
  assign halted_o   = (state_q == HALT);

endmodule : fetch_controller

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer sitting between the PC logic, the instruction memory port and the decode stage. Owns the fetch PC, issues one instruction-memory request at a time over a req/ack handshake, and delivers fetched words to decode through a two-entry output buffer (primary + skid) that absorbs decode stalls. Applies control-transfer redirects from X and M with M priority, including redirects that arrive while a fetch is in flight, generates pipeline flushes, and parks the front end on halt.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- hlt  in  1  halt request, level
- stall  in  1  decode not accepting; primary entry consumed at an edge where if_valid=1 and stall=0
- ct_taken_x  in  1  redirect from execute stage
- ct_pc_x  in  32  execute redirect target
- ct_taken_m  in  1  redirect from memory stage, overrides X
- ct_pc_m  in  32  memory redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  request accepted, imem_rdata valid this cycle
- imem_rdata  in  32  fetched word
- if_valid  out  1  primary entry valid
- if_ir  out  32  primary instruction
- if_pc  out  32  primary instruction address
- flush_d  out  1  kill decode-stage instruction
- flush_x  out  1  kill execute-stage instruction
- halted  out  1  front end parked

## Operation
- States: IDLE, FETCH, FULL, HALT. Redirect = ct_taken_m | ct_taken_x; target = ct_pc_m if ct_taken_m else ct_pc_x.
- Registers: pc, pend_pc, discard, primary (valid/ir/pc), skid (valid/ir/pc).
- IDLE: imem_req=0; next edge -> FETCH (pc <= target if redirect).
- FETCH: imem_req=1, imem_addr=pc. Without ack: on redirect, discard<=1, pend_pc<=target (latest redirect wins). With ack:
  - redirect same cycle: drop data, pc<=target, discard<=0, stay FETCH.
  - else if discard=1: drop data, pc<=pend_pc, discard<=0, stay FETCH.
  - else: pc<=pc+4 (mod 2^32). Word goes to primary if primary empty or consumed this edge (if skid valid, skid promotes first and word goes to skid). If primary held (stall=1, valid), word goes to skid and state -> FULL.
- FULL: imem_req=0. When primary consumed, skid -> primary, skid cleared, -> FETCH.
- Redirect in any state other than HALT: primary.valid<=0, skid.valid<=0 at that edge; in FULL, pc<=target, -> FETCH.
- flush_d = redirect (combinational). flush_x = ct_taken_m (combinational).
- Halt: at an edge with hlt=1 and (state!=FETCH or imem_ack=1) -> HALT; acked data dropped. hlt while request pending without ack waits for ack (handshake never abandoned). HALT: imem_req=0, if_valid=0, pc<=RESET_PC, halted=1; exits only via rst. Redirects ignored in HALT; flush outputs still follow inputs.
- Redirect and hlt same edge with halt qualified: HALT wins.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_ir=0, if_pc=0, skid empty, discard=0, halted=0; flush_* follow inputs.
- First request: cycle after rst deasserts; imem_req=1 with imem_addr=RESET_PC.
- Zero-wait memory (ack same cycle as req): word in primary one cycle later; sustained one fetch per cycle with stall=0.
- Redirect at edge N: new target on imem_addr from cycle N+1 if no request pending or ack at N; otherwise after pending ack plus one cycle.
- Back-to-back fetch: imem_req stays high; imem_addr changes only on the edge following ack.
- rst mid-fetch: everything returns to reset values immediately; outstanding memory transaction not tracked.

## Test plan
- Reset release, ack tied 1, stall=0 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc follows one cycle behind, if_ir = imem_rdata.
- stall=1 for 3 cycles with if_valid=1 -> second word captured in skid, state FULL, imem_req=0; stall drop -> skid promoted next cycle, fetch resumes at next address, no word lost or duplicated.
- ct_taken_x=1, ct_pc_x=0x100 while ack=0 (addr 0x8 pending), ack 2 cycles later -> data from 0x8 dropped, next imem_addr=0x100, flush_d=1 in redirect cycle only.
- ct_taken_x=1 (0x200) and ct_taken_m=1 (0x300) same cycle -> imem_addr=0x300, flush_d=1, flush_x=1.
- Redirect to 0xFFFF_FFFC, then sequential -> next imem_addr wraps to 0x0.
- hlt=1 with fetch pending -> imem_req held until ack, then halted=1, imem_req=0, if_valid=0; rst pulse -> restarts at RESET_PC.
